mem_arbiter2: RTL and testbench
===============================

// Module: mem_arbiter2
// PURPOSE
//  Two-requester round-robin arbiter sharing one synchronous 16-bit memory port
//  (iCE40 BRAM, 1-cycle read latency) between the Hack CPU data port (A) and a
//  loader/peripheral port (B). Sequences each access through IDLE/ISSUE/RESP and
//  returns read data with a one-cycle ack pulse. Only one access is in flight at a time.
// PARAMETERS
//  ADDR_W  15  address width, for 32K words
//  DATA_W  16  data word width
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       synchronous reset, active high
//  a_req      in   1       A request, level; held with command until a_ack
//  a_we       in   1       A write enable (1=write, 0=read)
//  a_addr     in   ADDR_W  A word address
//  a_wdata    in   DATA_W  A write data
//  a_ack      out  1       A done, one-cycle pulse
//  a_rdata    out  DATA_W  A read data, valid while a_ack=1, held afterwards
//  b_req/b_we/b_addr/b_wdata/b_ack/b_rdata  same as A, for requester B
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid the cycle after mem_en
//  busy       out  1       1 when state != IDLE
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active high.
//  - Reset: state=IDLE; all outputs 0, including a/b_rdata and mem_*.
//    rr pointer=B, so A wins the first tie.
//  - All outputs are registered.
//  - FSM states: IDLE, ISSUE, RESP.
//    IDLE: if any eligible req, latch the winner, go to ISSUE. Otherwise stay.
//    ISSUE: go to RESP. RESP: go to IDLE.
//  - In the ISSUE cycle: mem_en=1; mem_we/addr/wdata come from the winner's command
//    sampled in IDLE. mem_en=0 in every other state.
//  - In the RESP cycle: mem_rdata is valid. At the RESP->IDLE edge, the winner's ack is
//    registered to 1. For reads, the winner's rdata is registered to mem_rdata.
//    For writes, rdata keeps its previous value.
//  - Latency: req sampled in cycle N gives mem_en in N+1 and ack in N+3.
//    Peak throughput is one access per 3 cycles.
//  - The ack is high during the next IDLE cycle. In that cycle the requester being
//    acked is NOT eligible (masked), so a still-high req is not re-served.
//    Its req in the following cycle is a new request.
//  - Arbitration: if only one eligible req, grant it.
//    If both, grant the one not served last. The rr pointer updates on each grant.
//  - The other requester may be granted in an ack cycle, giving back-to-back service.
//  - A req that drops before its ack, or a command that changes before its ack,
//    is a protocol violation. Only IDLE-sampled values are used.
//  - Reset mid-operation: the transaction is aborted and no ack is issued.
//    A write whose ISSUE cycle already occurred is committed.
//  - a_ack and b_ack are never both 1 in the same cycle.
// TESTING (bench: 32Kx16 sync RAM model, 1-cycle read)
//  1. Reset: rst=1 for 2 cycles -> all outputs 0, busy=0.
//  2. A write 0x1234 @0x0005, then A read @0x0005 -> mem_en pulses 1 cycle each;
//     a_ack at req+3; a_rdata=0x1234.
//  3. Both req at the same edge after reset (A rd 0x0001, B rd 0x0002) -> A served first;
//     B granted in A's ack cycle; acks 3 cycles apart; rdata values correct.
//  4. A and B req held continuously for 6 accesses -> grants alternate A,B,A,B,A,B;
//     no double service.
//  5. rst asserted in the RESP cycle of a B read -> no b_ack; all outputs 0 next cycle;
//     next A request is served normally.
//  6. A write 0xFFFF @0x7FFF, then 0x0000 @0x0000 -> the address boundaries are stored
//     and read back correctly.
//     The a_rdata value from the earlier read is held through the intervening writes.

Source files
------------

// File: rtl/mem_arbiter2_if.sv
// Bus bundle between two memory requesters, the arbiter, and a single-port sync memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter2_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter sharing one 1-cycle-latency sync memory port between requesters A and B.
// Each access walks Idle -> Issue -> Resp; all outputs are registered.
module mem_arbiter2 #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter2_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q;
  logic              last_b_q;
  logic              sel_b_q;
  logic              a_ack_q, b_ack_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q;

  logic elig_a, elig_b, grant_any, grant_b;

  // A requester in its ack cycle is masked so its still-high req is not served twice.
  always_comb begin
    elig_a    = bus.a_req & ~a_ack_q;
    elig_b    = bus.b_req & ~b_ack_q;
    grant_any = elig_a | elig_b;
    grant_b   = elig_b & (~elig_a | ~last_b_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_b_q    <= 1'b1;
      sel_b_q     <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      mem_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            sel_b_q     <= grant_b;
            last_b_q    <= grant_b;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_b ? bus.b_we    : bus.a_we;
            mem_addr_q  <= grant_b ? bus.b_addr  : bus.a_addr;
            mem_wdata_q <= grant_b ? bus.b_wdata : bus.a_wdata;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: state_q <= StResp;
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (sel_b_q) begin
            b_ack_q <= 1'b1;
            if (!mem_we_q) b_rdata_q <= bus.mem_rdata;
          end else begin
            a_ack_q <= 1'b1;
            if (!mem_we_q) a_rdata_q <= bus.mem_rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with a 32Kx16 read-first sync RAM model.
module tb_mem_arbiter2;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  // Single access on one port; req dropped in the ack cycle. lat = -1 on timeout.
  task automatic access(input bit port_b, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rdata,
                        output int lat, output int en_cnt, output logic [ADDR_W-1:0] en_addr,
                        output logic en_we);
    @(negedge clk);
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    lat = -1; en_cnt = 0; en_addr = '0; en_we = 1'b0; rdata = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++; en_addr = bus.mem_addr; en_we = bus.mem_we;
      end
      if (port_b ? bus.b_ack : bus.a_ack) begin
        lat = c;
        rdata = port_b ? bus.b_rdata : bus.a_rdata;
        break;
      end
    end
    if (port_b) bus.b_req = 1'b0;
    else bus.a_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*DATA_W+ADDR_W+DATA_W+5-1:0] outs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    outs = {bus.a_ack, bus.a_rdata, bus.b_ack, bus.b_rdata, bus.mem_en, bus.mem_we,
            bus.mem_addr, bus.mem_wdata};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b, want 0", bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] rd; int lat, en; logic [ADDR_W-1:0] ea; logic ew;
    access(1'b0, 1'b1, 15'h0005, 16'h1234, rd, lat, en, ea, ew);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d, want 3", lat); end
    checks++;
    if (en !== 1) begin failures++; $display("FAIL wr_mem_en_pulses: got %0d, want 1", en); end
    checks++;
    if (ea !== 15'h0005 || ew !== 1'b1) begin
      failures++; $display("FAIL wr_mem_cmd: got addr=%h we=%b, want 0005/1", ea, ew);
    end
    access(1'b0, 1'b0, 15'h0005, 16'h0000, rd, lat, en, ea, ew);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d, want 3", lat); end
    checks++;
    if (en !== 1 || ew !== 1'b0) begin
      failures++; $display("FAIL rd_mem_en: got pulses=%0d we=%b, want 1/0", en, ew);
    end
    checks++;
    if (rd !== 16'h1234) begin failures++; $display("FAIL rd_data: got %h, want 1234", rd); end
  endtask

  task automatic test_tie();
    logic [DATA_W-1:0] rd, a_rd, b_rd; int lat, en, a_at, b_at, both; logic [ADDR_W-1:0] ea;
    logic ew;
    access(1'b0, 1'b1, 15'h0001, 16'hAAAA, rd, lat, en, ea, ew);
    access(1'b1, 1'b1, 15'h0002, 16'hBBBB, rd, lat, en, ea, ew);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 15'h0001;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 15'h0002;
    a_at = -1; b_at = -1; both = 0; a_rd = '0; b_rd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.a_ack && bus.b_ack) both++;
      if (bus.a_ack && a_at < 0) begin a_at = c; a_rd = bus.a_rdata; bus.a_req = 1'b0; end
      if (bus.b_ack && b_at < 0) begin b_at = c; b_rd = bus.b_rdata; bus.b_req = 1'b0; end
      if (a_at >= 0 && b_at >= 0) break;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    checks++;
    if (a_at !== 3 || b_at !== 6) begin
      failures++; $display("FAIL tie_ack_cycles: got a=%0d b=%0d, want a=3 b=6", a_at, b_at);
    end
    checks++;
    if (a_rd !== 16'hAAAA || b_rd !== 16'hBBBB) begin
      failures++; $display("FAIL tie_rdata: got a=%h b=%h, want AAAA BBBB", a_rd, b_rd);
    end
    checks++;
    if (both !== 0) begin failures++; $display("FAIL tie_dual_ack: got %0d, want 0", both); end
  endtask

  task automatic test_alternate();
    int seq [6]; int at [6]; logic ok [6]; int n, both, extra;
    n = 0; both = 0; extra = 0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 15'h0005;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 15'h0002;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(negedge clk);
      if (bus.a_ack && bus.b_ack) both++;
      if (bus.a_ack) begin seq[n] = 0; at[n] = c; ok[n] = (bus.a_rdata === 16'h1234); n++; end
      else if (bus.b_ack) begin seq[n] = 1; at[n] = c; ok[n] = (bus.b_rdata === 16'hBBBB); n++; end
      if (n == 6) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    checks++;
    if (n !== 6) begin failures++; $display("FAIL alt_count: got %0d, want 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq[i] !== i % 2 || at[i] !== 3 * (i + 1) || !ok[i]) begin
        failures++;
        $display("FAIL alt_grant%0d: got port=%0d cycle=%0d data_ok=%b, want port=%0d cycle=%0d",
                 i, seq[i], at[i], ok[i], i % 2, 3 * (i + 1));
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) extra++;
    end
    checks++;
    if (both !== 0 || extra !== 0) begin
      failures++; $display("FAIL alt_double_service: got dual=%0d extra=%0d, want 0 0", both, extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] rd; int lat, en; logic [ADDR_W-1:0] ea; logic ew;
    logic [2*DATA_W+ADDR_W+DATA_W+5-1:0] outs;
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 15'h0002;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1) begin failures++; $display("FAIL mid_issue: got %b, want 1", bus.mem_en); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b, want 1", bus.busy); end
    rst = 1'b1; bus.b_req = 1'b0;
    @(negedge clk);
    outs = {bus.a_ack, bus.a_rdata, bus.b_ack, bus.b_rdata, bus.mem_en, bus.mem_we,
            bus.mem_addr, bus.mem_wdata};
    checks++;
    if (outs !== '0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outputs: got %h busy=%b, want 0", outs, bus.busy);
    end
    rst = 1'b0;
    access(1'b0, 1'b0, 15'h0005, 16'h0000, rd, lat, en, ea, ew);
    checks++;
    if (lat !== 3 || rd !== 16'h1234) begin
      failures++; $display("FAIL mid_recover: got lat=%0d data=%h, want 3 1234", lat, rd);
    end
  endtask

  task automatic test_boundary();
    logic [DATA_W-1:0] rd; int lat, en; logic [ADDR_W-1:0] ea; logic ew;
    access(1'b0, 1'b1, 15'h7FFF, 16'hFFFF, rd, lat, en, ea, ew);
    checks++;
    if (ea !== 15'h7FFF || rd !== 16'h1234) begin
      failures++; $display("FAIL bnd_wr_hi: got addr=%h rdata=%h, want 7FFF 1234", ea, rd);
    end
    access(1'b0, 1'b1, 15'h0000, 16'h0000, rd, lat, en, ea, ew);
    checks++;
    if (lat !== 3 || rd !== 16'h1234) begin
      failures++; $display("FAIL bnd_wr_lo: got lat=%0d rdata=%h, want 3 1234", lat, rd);
    end
    access(1'b0, 1'b0, 15'h7FFF, 16'h0000, rd, lat, en, ea, ew);
    checks++;
    if (rd !== 16'hFFFF) begin failures++; $display("FAIL bnd_rd_hi: got %h, want FFFF", rd); end
    access(1'b0, 1'b0, 15'h0000, 16'h0000, rd, lat, en, ea, ew);
    checks++;
    if (lat !== 3 || rd !== 16'h0000) begin
      failures++; $display("FAIL bnd_rd_lo: got lat=%0d data=%h, want 3 0000", lat, rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    test_reset();
    test_write_read();
    test_tie();
    test_alternate();
    test_reset_mid();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
